// File: rtl/memory_access.sv
// MEM stage: drives the data-memory req/ack handshake, stalls the pipeline while an access is
// outstanding, aligns load data and owns the MEM/WB pipeline registers.
module memory_access (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PIP_mem_read_i,
    input  logic        PIP_mem_write_i,
    input  logic [2:0]  PIP_funct3_i,
    input  logic [31:0] PIP_alu_result_i,
    input  logic [31:0] PIP_rs2_data_i,
    input  logic        PIP_write_reg_i,
    input  logic [4:0]  PIP_rd_i,
    input  logic        PIP_TRAP_i,
    output logic        DMEM_req_o,
    output logic        DMEM_we_o,
    output logic [31:0] DMEM_addr_o,
    output logic [3:0]  DMEM_be_o,
    output logic [31:0] DMEM_wdata_o,
    input  logic        DMEM_ack_i,
    input  logic [31:0] DMEM_rdata_i,
    output logic        MEM_stall_o,
    output logic        PIP_use_mem_o,
    output logic        PIP_write_reg_o,
    output logic [31:0] PIP_DMEM_data_o,
    output logic [31:0] PIP_alu_result_o,
    output logic [4:0]  PIP_rd_o,
    output logic        PIP_TRAP_o
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic        mem_op, misaligned, illegal, bad, access;
    logic [1:0]  size, lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    logic        use_mem_q, write_reg_q, trap_q;
    logic [31:0] dmem_data_q, alu_result_q;
    logic [4:0]  rd_q;

    assign size = PIP_funct3_i[1:0];
    assign lane = PIP_alu_result_i[1:0];
    assign mem_op = PIP_mem_read_i | PIP_mem_write_i;

    assign misaligned = ((size == 2'b01) && lane[0]) || ((size == 2'b10) && (lane != 2'b00));
    assign illegal = (PIP_mem_read_i && ((PIP_funct3_i == 3'b011) || (PIP_funct3_i == 3'b110) ||
                                         (PIP_funct3_i == 3'b111))) ||
                     (PIP_mem_write_i && (PIP_funct3_i[2] || (PIP_funct3_i == 3'b011)));
    // Only memory ops can be bad; ALU ops reuse funct3 for unrelated encodings.
    assign bad = mem_op & (misaligned | illegal);
    assign access = mem_op & ~PIP_TRAP_i & ~bad;

    always_comb begin
        state_d = state_q;
        DMEM_req_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                DMEM_req_o = access;
                if (access && !DMEM_ack_i) state_d = StWait;
            end
            StWait: begin
                DMEM_req_o = 1'b1;
                if (DMEM_ack_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Request and stall must vanish the instant reset is asserted, not at the next edge.
        if (!reset_n) DMEM_req_o = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    assign MEM_stall_o = DMEM_req_o & ~DMEM_ack_i;

    assign DMEM_we_o   = PIP_mem_write_i;
    assign DMEM_addr_o = {PIP_alu_result_i[31:2], 2'b00};

    always_comb begin
        DMEM_be_o    = 4'b1111;
        DMEM_wdata_o = PIP_rs2_data_i;
        unique case (size)
            2'b00: begin
                DMEM_be_o    = 4'b0001 << lane;
                DMEM_wdata_o = {4{PIP_rs2_data_i[7:0]}};
            end
            2'b01: begin
                DMEM_be_o    = 4'b0011 << {lane[1], 1'b0};
                DMEM_wdata_o = {2{PIP_rs2_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = DMEM_rdata_i[7:0];
        unique case (lane)
            2'b00: ld_byte = DMEM_rdata_i[7:0];
            2'b01: ld_byte = DMEM_rdata_i[15:8];
            2'b10: ld_byte = DMEM_rdata_i[23:16];
            2'b11: ld_byte = DMEM_rdata_i[31:24];
            default: ;
        endcase
        ld_half = lane[1] ? DMEM_rdata_i[31:16] : DMEM_rdata_i[15:0];
        ld_data = DMEM_rdata_i;
        unique case (PIP_funct3_i)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = DMEM_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            use_mem_q    <= 1'b0;
            write_reg_q  <= 1'b0;
            trap_q       <= 1'b0;
            dmem_data_q  <= 32'h0;
            alu_result_q <= 32'h0;
            rd_q         <= 5'h0;
        end else if (MEM_stall_o) begin
            use_mem_q    <= 1'b0;
            write_reg_q  <= 1'b0;
            trap_q       <= 1'b0;
            dmem_data_q  <= 32'h0;
            alu_result_q <= 32'h0;
            rd_q         <= 5'h0;
        end else begin
            use_mem_q    <= PIP_mem_read_i & access;
            write_reg_q  <= PIP_write_reg_i & ~bad;
            trap_q       <= PIP_TRAP_i | bad;
            dmem_data_q  <= (PIP_mem_read_i && access && DMEM_ack_i) ? ld_data : 32'h0;
            alu_result_q <= PIP_alu_result_i;
            rd_q         <= PIP_rd_i;
        end
    end

    assign PIP_use_mem_o    = use_mem_q;
    assign PIP_write_reg_o  = write_reg_q;
    assign PIP_TRAP_o       = trap_q;
    assign PIP_DMEM_data_o  = dmem_data_q;
    assign PIP_alu_result_o = alu_result_q;
    assign PIP_rd_o         = rd_q;

endmodule

// File: doc/memory_access.md
# memory_access

MEM stage of the pipelined RISC-V core, sitting between the EX/MEM pipeline registers and the write-back stage, whose MEM/WB inputs it drives. Performs loads and stores over a req/ack data-memory handshake with variable wait states and stalls the pipeline while an access is outstanding. Generates byte enables, aligns and extends load data, and raises a trap on misaligned or unsupported accesses. Owns the MEM/WB pipeline registers.

## Interface
- No parameters; data/address width fixed at 32.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- PIP_mem_read_i  in  1  load in EX/MEM
- PIP_mem_write_i  in  1  store in EX/MEM
- PIP_funct3_i  in  3  access size/sign (RV32I encoding)
- PIP_alu_result_i  in  32  effective address / ALU result
- PIP_rs2_data_i  in  32  store data (unaligned, low bits)
- PIP_write_reg_i  in  1  instruction writes rd
- PIP_rd_i  in  5  destination register
- PIP_TRAP_i  in  1  trap already raised upstream
- DMEM_req_o  out  1  access request
- DMEM_we_o  out  1  1 = write
- DMEM_addr_o  out  32  word address ({addr[31:2],2'b00})
- DMEM_be_o  out  4  byte enables
- DMEM_wdata_o  out  32  lane-replicated store data
- DMEM_ack_i  in  1  access complete; rdata valid same cycle
- DMEM_rdata_i  in  32  read word
- MEM_stall_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- PIP_use_mem_o, PIP_write_reg_o  out  1 each  MEM/WB controls
- PIP_DMEM_data_o, PIP_alu_result_o  out  32 each  MEM/WB data
- PIP_rd_o  out  5;  PIP_TRAP_o  out  1

## Operation
- access = (mem_read|mem_write) & !PIP_TRAP_i & !bad; bad = misaligned | illegal funct3.
- Misaligned: halfword (funct3[1:0]=01) with addr[0]=1; word (10) with addr[1:0]≠0. Illegal: loads 011/110/111, stores funct3[2]=1 or 011.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111. wdata: byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}, word rs2.
- Load format: select byte/half lane by addr[1:0]; 000/001 sign-extend, 100/101 zero-extend, 010 full word.
- FSM IDLE/WAIT. DMEM_req_o = (IDLE & access) | WAIT. IDLE→WAIT on req & !ack; WAIT→IDLE on ack. addr/we/be/wdata come from held EX/MEM inputs (stable under stall).
- MEM_stall_o = DMEM_req_o & !DMEM_ack_i (combinational).
- MEM/WB update each non-stalled cycle: use_mem←mem_read&access, write_reg←PIP_write_reg_i&!bad, DMEM_data←formatted rdata (0 unless load acked), alu_result, rd, TRAP←PIP_TRAP_i|(mem op & bad).
- While stalled: MEM/WB loads a bubble (write_reg=0, use_mem=0, TRAP=0); other fields don't-care but zeroed.
- Trapped/bad instruction never asserts DMEM_req_o.

## Timing
- Reset: state IDLE, all MEM/WB outputs 0; DMEM_req_o, MEM_stall_o drop asynchronously with reset_n.
- Zero-wait access (ack in request cycle): no stall, result in MEM/WB next edge — 1-cycle stage latency.
- N wait states: stall asserted N cycles, MEM/WB shows N bubbles then the result.
- Request, once raised, held with stable addr/we/be/wdata until ack.
- Non-memory instructions: pass through in 1 cycle, never stall.
- Reset mid-WAIT: access abandoned, no MEM/WB write; a late ack after reset in IDLE with no request is ignored.

## Test plan
- Reset, then LW addr 0x100, ack same cycle with rdata 0xDEADBEEF → no stall; next cycle use_mem=1, DMEM_data=0xDEADBEEF, be=4'b1111.
- LB addr 0x103, rdata 0x80xxxxxx → be irrelevant for load, DMEM_data=0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102, rdata 0xBEEF1234 → 0x0000BEEF.
- SH addr 0x202, rs2=0x0000ABCD, ack after 3 cycles → req/we high 4 cycles, be=4'b1100, wdata=0xABCDABCD, stall 3 cycles, 3 bubbles then write_reg=0 entry.
- LW addr 0x101 → no req, PIP_TRAP_o=1, write_reg=0 next cycle; PIP_TRAP_i=1 with SW → no req, trap propagated.
- Assert reset_n low during WAIT → req/stall drop immediately, MEM/WB all 0; following ADD (write_reg=1, rd=5, alu=7) passes in 1 cycle.
